// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/IO bridge: FSM state encoding,
// the IO window base address and an elaboration-time clog2 helper.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] IO_BASE = 32'hFFFFFC00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_io_if.sv
// Bus bundle between CPU datapath, data memory and the IO channels.
// slave = bridge view, master = environment (CPU/memory/peripheral) view.
interface mem_io_if #(
  parameter int NCH  = 4,
  parameter int IO_W = 16
);
  logic                  mRead;
  logic                  mWrite;
  logic                  ioRead;
  logic                  ioWrite;
  logic [31:0]           addr_in;
  logic [31:0]           r_rdata;
  logic [31:0]           m_rdata;
  logic [31:0]           addr_out;
  logic [31:0]           m_wdata;
  logic                  m_we;
  logic [NCH-1:0]        io_sel;
  logic                  io_req;
  logic                  io_we;
  logic [IO_W-1:0]       io_wdata;
  logic                  io_ack;
  logic [NCH*IO_W-1:0]   io_rdata;
  logic [31:0]           r_wdata;
  logic                  stall;
  logic                  io_err;

  // Handshake: io_req rises with a one-hot io_sel and stays high (with io_sel,
  // io_we, io_wdata stable) until io_ack is sampled high on a rising clock;
  // that edge completes the transfer and io_req drops. io_ack is ignored
  // whenever io_req is low.
  modport slave (
    input  mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata, m_rdata,
           io_ack, io_rdata,
    output addr_out, m_wdata, m_we, io_sel, io_req, io_we, io_wdata,
           r_wdata, stall, io_err
  );

  modport master (
    output mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata, m_rdata,
           io_ack, io_rdata,
    input  addr_out, m_wdata, m_we, io_sel, io_req, io_we, io_wdata,
           r_wdata, stall, io_err
  );

endinterface

// File: rtl/io_chan_mux.sv
// Channel index decode: one-hot select plus the matching read-data slice.
// Out-of-range indices give an all-zero select and zero data.
module io_chan_mux #(
  parameter int NCH   = 4,
  parameter int IO_W  = 16,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [NCH*IO_W-1:0]   i_rdata,
  output logic [NCH-1:0]        o_sel,
  output logic [IO_W-1:0]       o_rdata
);

  always_comb begin
    o_sel   = '0;
    o_rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(i_idx) == k) begin
        o_sel[k] = 1'b1;
        o_rdata  = i_rdata[k*IO_W +: IO_W];
      end
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: combinational data-memory passthrough plus a stalling
// multi-cycle IO handshake. Optional IO timeout enabled by `define IO_TIMEOUT_EN.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IO_W     = 16,
  parameter int CH_SHIFT = 4,
  parameter int SIGN_EXT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic      clock,
  input  logic      reset,
  mem_io_if.slave   bus,
  output state_t    o_dbg_state
);

  // One bit wider than needed so an out-of-range channel is always encodable.
  localparam int IDX_W = clog2(NCH) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_ch;
  logic              r_we;
  logic [IO_W-1:0]   r_io_wdata;
  logic [IO_W-1:0]   r_io_rdata;
  logic [IDX_W-1:0]  w_ch;
  logic              w_io_acc;
  logic              w_ch_ok;
  logic [NCH-1:0]    w_sel;
  logic [IO_W-1:0]   w_slice;
  logic [31:0]       w_ext;
  logic              w_expired;

  assign w_io_acc = bus.ioRead | bus.ioWrite;
  assign w_ch     = bus.addr_in[CH_SHIFT +: IDX_W];
  assign w_ch_ok  = (int'(w_ch) < NCH);

  io_chan_mux #(
    .NCH   (NCH),
    .IO_W  (IO_W),
    .IDX_W (IDX_W)
  ) u_chan_mux (
    .i_idx   (r_ch),
    .i_rdata (bus.io_rdata),
    .o_sel   (w_sel),
    .o_rdata (w_slice)
  );

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 255) ? 16 : 8;
  logic [TO_W-1:0] r_cnt;
  logic            r_err;

  assign w_expired = (r_state == REQ) && !bus.io_ack &&
                     (r_cnt == TO_W'(TIMEOUT - 1));

  // Counter sits at zero outside REQ, so it is clear on every REQ entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_expired;
      if (r_state != REQ) r_cnt <= '0;
      else                r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.io_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_expired        = 1'b0;
  assign bus.io_err       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_we       <= 1'b0;
      r_io_wdata <= '0;
      r_io_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_io_acc) begin
        r_ch       <= w_ch;
        r_we       <= bus.ioWrite;
        r_io_wdata <= bus.r_rdata[IO_W-1:0];
        r_io_rdata <= '0;
      end
      if (r_state == REQ && bus.io_ack && !r_we) r_io_rdata <= w_slice;
      if (w_expired) r_io_rdata <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_io_acc) w_next = w_ch_ok ? REQ : DONE;
      REQ:     if (bus.io_ack || w_expired) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  generate
    if (IO_W == 32) begin : g_no_ext
      assign w_ext = 32'(r_io_rdata);
    end else if (SIGN_EXT != 0) begin : g_sign_ext
      assign w_ext = {{(32-IO_W){r_io_rdata[IO_W-1]}}, r_io_rdata};
    end else begin : g_zero_ext
      assign w_ext = {{(32-IO_W){1'b0}}, r_io_rdata};
    end
  endgenerate

  // IO has priority over an (illegal) simultaneous memory write.
  assign bus.addr_out = bus.addr_in;
  assign bus.m_wdata  = bus.r_rdata;
  assign bus.m_we     = bus.mWrite & ~w_io_acc;
  assign bus.r_wdata  = (r_state == DONE) ? w_ext :
                        (bus.mRead ? bus.m_rdata : 32'd0);

  assign bus.io_req   = (r_state == REQ);
  assign bus.io_sel   = (r_state == REQ) ? w_sel : '0;
  assign bus.io_we    = r_we;
  assign bus.io_wdata = r_io_wdata;
  assign bus.stall    = w_io_acc & (r_state != DONE);

  assign o_dbg_state  = r_state;

endmodule
